// File: rtl/pkg_led.sv
// Shared definitions for the LED pattern engine and its step prescaler.
package pkg_led;

   // Pattern mode encodings as seen on i_mode; 6 and 7 are reserved (all LEDs off).
   typedef enum logic [2:0] {
      MODE_ROT_L  = 3'd0,
      MODE_ROT_R  = 3'd1,
      MODE_BOUNCE = 3'd2,
      MODE_COUNT  = 3'd3,
      MODE_FILL   = 3'd4,
      MODE_DECODE = 3'd5,
      MODE_RSV_6  = 3'd6,
      MODE_RSV_7  = 3'd7
   } mode_e;

   // LEDs are active-low: this is the level of an unlit LED. Replicate it to
   // the LED count to get the all-off drive.
   localparam logic LED_ALL_OFF = 1'b1;

   // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'd1 << i) < value) res = i + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/led_step_tick.sv
// Programmable step prescaler: divides i_clk down to STEP_HZ * 2^i_speed and
// emits a one-cycle strobe per step. Shared with the nixie scan driver.
//
// Strobe semantics: o_step is a plain one-cycle pulse with no handshake. A
// consumer acts on the rising i_clk edge at which o_step is high; there is no
// back-pressure and a missed strobe is simply lost.
module led_step_tick
   import pkg_led::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int STEP_HZ     = 1
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_speed,
   input  logic       i_pause,
   input  logic       i_clear,
   output logic       o_step
);

   localparam int BASE  = CLK_FREQ_HZ / STEP_HZ;
   localparam int CNT_W = (clog2(BASE) < 1) ? 1 : clog2(BASE);

   logic [CNT_W-1:0] cnt;
   logic [31:0]      term;
   logic             hit;

   // Terminal count for the selected rate (floored at 0). The >= compare lets a
   // speed increase while running fire immediately instead of overrunning.
   always_comb begin
      term = 32'(BASE) >> i_speed;
      if (term != 32'd0) term = term - 32'd1;
      hit    = (32'(cnt) >= term);
      o_step = hit && !i_pause && !i_clear;
   end

   // Counter: clear wins, pause holds, otherwise wrap on terminal count.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt <= '0;
      end else if (i_clear) begin
         cnt <= '0;
      end else if (!i_pause) begin
         if (hit) cnt <= '0;
         else     cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/led_pattern_engine.sv
// Multi-mode active-low LED pattern driver. Pattern state advances on each
// prescaler strobe; a change of i_mode reloads the mode's initial pattern.
module led_pattern_engine
   import pkg_led::*;
#(
   parameter int LED_NUM     = 8,
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int STEP_HZ     = 1,
   parameter int SEL_W       = 3
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [2:0]         i_mode,
   input  logic [1:0]         i_speed,
   input  logic               i_pause,
   input  logic [SEL_W-1:0]   i_sel,
   output logic [LED_NUM-1:0] o_led,
   output logic               o_step
);

   localparam logic [LED_NUM-1:0] LED_ONE   = LED_NUM'(1);
   localparam logic [LED_NUM-1:0] POS_LAST  = LED_NUM'(LED_NUM - 1);
   localparam logic [LED_NUM-1:0] FILL_FULL = LED_NUM'(LED_NUM);
   localparam logic [LED_NUM-1:0] ALL_OFF   = {LED_NUM{LED_ALL_OFF}};

   // Complete pattern state in one struct so it can be observed as a unit.
   typedef struct packed {
      mode_e              mode;    // i_mode registered every cycle
      logic               live;    // 0 after reset until the first step: LEDs dark
      logic               dir_dn;  // BOUNCE travel direction
      logic [LED_NUM-1:0] val;     // position, count or fill level per mode
   } pat_state_t;

   pat_state_t         st_q;
   pat_state_t         st_d;
   logic [LED_NUM-1:0] led_d;
   mode_e              mode_in;
   logic               mode_chg;
   logic               step;

   assign mode_in  = mode_e'(i_mode);
   assign mode_chg = (mode_in != st_q.mode);
   assign o_step   = step;

   // A mode change clears the prescaler and swallows any coincident step.
   led_step_tick #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .STEP_HZ     (STEP_HZ)
   ) u_tick (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_speed (i_speed),
      .i_pause (i_pause),
      .i_clear (mode_chg),
      .o_step  (step)
   );

   // Next pattern state: mode reload has priority over a step.
   always_comb begin
      st_d      = st_q;
      st_d.mode = mode_in;
      if (mode_chg) begin
         st_d.live   = 1'b1;
         st_d.dir_dn = 1'b0;
         st_d.val    = (mode_in == MODE_ROT_R) ? POS_LAST : '0;
      end else if (step) begin
         if (!st_q.live) begin
            // First step after reset shows the initial pattern without advancing.
            st_d.live = 1'b1;
         end else begin
            case (st_q.mode)
               MODE_ROT_L: st_d.val = (st_q.val == POS_LAST) ? '0 : st_q.val + LED_ONE;
               MODE_ROT_R: st_d.val = (st_q.val == '0) ? POS_LAST : st_q.val - LED_ONE;
               MODE_BOUNCE: begin
                  if (st_q.val == POS_LAST) begin
                     st_d.dir_dn = 1'b1;
                     st_d.val    = st_q.val - LED_ONE;
                  end else if (st_q.val == '0) begin
                     st_d.dir_dn = 1'b0;
                     st_d.val    = st_q.val + LED_ONE;
                  end else begin
                     st_d.val = st_q.dir_dn ? st_q.val - LED_ONE : st_q.val + LED_ONE;
                  end
               end
               MODE_COUNT: st_d.val = st_q.val + LED_ONE;
               MODE_FILL:  st_d.val = (st_q.val == FILL_FULL) ? '0 : st_q.val + LED_ONE;
               default:    st_d.val = st_q.val;
            endcase
         end
      end
   end

   // LED drive for the next state; FILL shifts ones out from the bottom so the
   // low k LEDs are lit, and a shift by LED_NUM lights them all.
   always_comb begin
      led_d = ALL_OFF;
      if (st_d.live) begin
         case (st_d.mode)
            MODE_ROT_L, MODE_ROT_R, MODE_BOUNCE: led_d = ~(LED_ONE << st_d.val);
            MODE_COUNT:  led_d = ~st_d.val;
            MODE_FILL:   led_d = ALL_OFF << st_d.val;
            MODE_DECODE: begin
               if (32'(i_sel) < 32'(LED_NUM)) led_d = ~(LED_ONE << i_sel);
            end
            default:     led_d = ALL_OFF;
         endcase
      end
   end

   // State and LED output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         st_q  <= '{mode: MODE_ROT_L, live: 1'b0, dir_dn: 1'b0, val: '0};
         o_led <= ALL_OFF;
      end else begin
         st_q  <= st_d;
         o_led <= led_d;
      end
   end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine: directed pattern sequences checked by a
// step-triggered scoreboard, plus direct checks of reset, mode reload and DECODE.
module tb_led_pattern_engine;

   logic       clk;
   logic       rst_n;
   logic [2:0] mode;
   logic [1:0] speed;
   logic       pause;
   logic [2:0] sel;
   logic [7:0] o_led;
   logic       o_step;
   logic [5:0] o_led6;
   logic       o_step6;

   int n_checks = 0;
   int n_errors = 0;

   // Expected entries: {gap, led}; gap = cycles since previous step, 0 = not checked.
   logic [15:0] exp_q[$];
   logic        mon_en;
   logic        pend;
   int          ncyc = 0;
   int          last_step = 0;
   int          n_pause_steps;

   led_pattern_engine #(
      .LED_NUM(8), .CLK_FREQ_HZ(16), .STEP_HZ(1), .SEL_W(3)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_speed(speed),
      .i_pause(pause), .i_sel(sel), .o_led(o_led), .o_step(o_step)
   );

   led_pattern_engine #(
      .LED_NUM(6), .CLK_FREQ_HZ(16), .STEP_HZ(1), .SEL_W(3)
   ) dut6 (
      .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_speed(speed),
      .i_pause(pause), .i_sel(sel), .o_led(o_led6), .o_step(o_step6)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected to have finished");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] led, input logic [7:0] gap);
      exp_q.push_back({gap, led});
   endtask

   task automatic wait_drain(input string name, input int max_cyc);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_timeout: %0d entries left, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Monitor: a step strobe seen mid-cycle means the following edge advanced the
   // pattern; compare o_led (and step spacing) at the next falling edge.
   always @(negedge clk) begin
      logic [15:0] e;
      ncyc = ncyc + 1;
      if (pend) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_step: o_led=%h, expected no step", o_led);
         end else begin
            e = exp_q.pop_front();
            check("step_led", 32'(o_led), 32'(e[7:0]));
            if (e[15:8] != 8'd0) check("step_gap", 32'(ncyc - last_step), 32'(e[15:8]));
         end
         last_step = ncyc;
      end
      pend = mon_en && rst_n && o_step;
   end

   // Directed stimulus tables
   logic [7:0] tab_rot_l[11]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F,
                                  8'hFE, 8'hFD, 8'hFB};
   logic [7:0] tab_bounce[19] = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hBF,
                                  8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hFD, 8'hFB,
                                  8'hF7, 8'hEF, 8'hDF};
   logic [7:0] tab_rot_r[8]   = '{8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'h7F};
   logic [7:0] tab_fill[10]   = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00,
                                  8'hFF, 8'hFE};
   logic [7:0] tab_count[5]   = '{8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFA};

   // Main stimulus
   initial begin
      rst_n  = 1'b0;
      mode   = 3'd0;
      speed  = 2'd0;
      pause  = 1'b0;
      sel    = 3'd0;
      mon_en = 1'b1;
      pend   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_led", 32'(o_led), 32'h0000_00FF);
      check("reset_step", 32'(o_step), 32'd0);
      check("reset_led6", 32'(o_led6), 32'h0000_003F);
      check("reset_step6", 32'(o_step6), 32'd0);

      // ROTATE_L at base rate, one step every 16 cycles
      foreach (tab_rot_l[i]) push(tab_rot_l[i], (i == 0) ? 8'd0 : 8'd16);
      rst_n = 1'b1;
      wait_drain("rot_l", 400);

      // Pause at FB for 40 cycles; the next step comes 16 + 40 cycles after FB
      push(8'hF7, 8'd56);
      pause = 1'b1;
      n_pause_steps = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (o_step) n_pause_steps++;
      end
      check("pause_steps", 32'(n_pause_steps), 32'd0);
      check("pause_hold_led", 32'(o_led), 32'h0000_00FB);
      pause = 1'b0;
      wait_drain("pause", 100);

      // Speed 0 -> 3 with cnt = 10: immediate step, then every 2 cycles
      repeat (9) @(posedge clk);
      #1;
      speed = 2'd3;
      push(8'hEF, 8'd11);
      push(8'hDF, 8'd2);
      push(8'hBF, 8'd2);
      wait_drain("speed_up", 40);

      // BOUNCE: 14-step period, then on to bit 5
      mode = 3'd2;
      @(posedge clk);
      #1;
      check("bounce_init", 32'(o_led), 32'h0000_00FE);
      foreach (tab_bounce[i]) push(tab_bounce[i], (i == 0) ? 8'd4 : 8'd2);
      wait_drain("bounce", 100);

      // Mode change on the same edge as a step: reload, no advance, cnt cleared
      mode = 3'd0;
      @(posedge clk);
      #1;
      check("chg_on_step_led", 32'(o_led), 32'h0000_00FE);
      push(8'hFD, 8'd4);
      wait_drain("chg_on_step", 20);

      // ROTATE_R at speed 2, one step every 4 cycles
      mode  = 3'd1;
      speed = 2'd2;
      @(posedge clk);
      #1;
      check("rot_r_init", 32'(o_led), 32'h0000_007F);
      foreach (tab_rot_r[i]) push(tab_rot_r[i], (i == 0) ? 8'd6 : 8'd4);
      wait_drain("rot_r", 100);

      // FILL, period 9
      mode  = 3'd4;
      speed = 2'd3;
      @(posedge clk);
      #1;
      check("fill_init", 32'(o_led), 32'h0000_00FF);
      foreach (tab_fill[i]) push(tab_fill[i], (i == 0) ? 8'd4 : 8'd2);
      wait_drain("fill", 100);

      // COUNT: five steps give ~5
      mode = 3'd3;
      @(posedge clk);
      #1;
      check("count_init", 32'(o_led), 32'h0000_00FF);
      foreach (tab_count[i]) push(tab_count[i], (i == 0) ? 8'd4 : 8'd2);
      wait_drain("count", 60);

      // Asynchronous reset mid-COUNT, then mode 0 restarts from bit 0
      rst_n = 1'b0;
      #1;
      check("rst_async_led", 32'(o_led), 32'h0000_00FF);
      check("rst_async_step", 32'(o_step), 32'd0);
      mode  = 3'd0;
      speed = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      push(8'hFE, 8'd0);
      push(8'hFD, 8'd16);
      rst_n = 1'b1;
      wait_drain("restart", 100);

      // DECODE: steps keep pulsing but do not move the pattern
      mon_en = 1'b0;
      mode   = 3'd5;
      sel    = 3'd3;
      @(posedge clk);
      #1;
      check("decode_3", 32'(o_led), 32'h0000_00F7);
      check("decode6_3", 32'(o_led6), 32'h0000_0037);
      sel = 3'd0;
      #1;
      check("decode_latency", 32'(o_led), 32'h0000_00F7);
      @(posedge clk);
      #1;
      check("decode_0", 32'(o_led), 32'h0000_00FE);
      check("decode6_0", 32'(o_led6), 32'h0000_003E);
      sel = 3'd7;
      @(posedge clk);
      #1;
      check("decode_7", 32'(o_led), 32'h0000_007F);
      check("decode6_7_off", 32'(o_led6), 32'h0000_003F);
      sel = 3'd5;
      @(posedge clk);
      #1;
      check("decode_5", 32'(o_led), 32'h0000_00DF);
      check("decode6_5", 32'(o_led6), 32'h0000_001F);

      // Reserved mode: all off
      mode = 3'd6;
      @(posedge clk);
      #1;
      check("reserved_led", 32'(o_led), 32'h0000_00FF);
      check("reserved_led6", 32'(o_led6), 32'h0000_003F);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
